id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register and the 32×32 general register file, and reads forwarded operands. It resolves every control transfer (beq, bne, blez, bgtz, bltz, bgez, j, jal, jr) in ID and returns `npc`/`npc_sel` to fetch, using one architectural delay slot. Its outputs feed the ID/EX register.

## Interface
- `RESET_PC`, default 32'h00003000: PC value loaded into the IF/ID register on reset.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `if_instr`  in  32  instruction from fetch.
- `if_pc4`  in  32  fetch PC+4.
- `id_en`  in  1  1 = IF/ID latches new values; 0 = hold. Same signal drives fetch `cont`.
- `wb_we`  in  1  register-file write enable.
- `wb_waddr`  in  5  write address.
- `wb_wdata`  in  32  write data.
- `fwd_rs_sel`  in  2  rs operand source: 0 = GRF, 1 = `fwd_em_data`, 2 = `fwd_mw_data`, 3 = GRF.
- `fwd_rt_sel`  in  2  rt operand source, same encoding as `fwd_rs_sel`.
- `fwd_em_data`  in  32  EX/MEM forwarded value.
- `fwd_mw_data`  in  32  MEM/WB forwarded value.
- `id_instr`  out  32  registered instruction.
- `id_pc4`  out  32  registered PC+4.
- `rs_data`  out  32  forwarded rs operand.
- `rt_data`  out  32  forwarded rt operand.
- `ext_imm`  out  32  extended immediate.
- `npc`  out  32  control-transfer target.
- `npc_sel`  out  1  1 = fetch loads `npc`.

## Operation
- **IF/ID register**
  - On reset: `id_instr` = 0 (nop), `id_pc4` = `RESET_PC`.
  - Otherwise, when `id_en` = 1, latch `if_instr` and `if_pc4`.
  - When `id_en` = 0, hold both values.
- **GRF**
  - Reset clears all 32 registers to 0.
  - Write on posedge when `wb_we` = 1 and `wb_waddr` != 0. Writes to $0 are ignored; $0 always reads 0.
  - Reads are combinational on rs = `id_instr[25:21]` and rt = `id_instr[20:16]`.
  - Internal bypass: if `wb_we` = 1, `wb_waddr` != 0 and `wb_waddr` equals the read address, the read returns `wb_wdata` in the same cycle.
  - GRF writes proceed regardless of `id_en`.
- **Forwarding**
  - `rs_data` and `rt_data` are the forwarding-mux outputs.
  - All branch comparisons and the jr target use these muxed values.
- **Immediate extension**
  - lui (001111): {imm, 16'h0}.
  - andi/ori/xori (0011xx, excluding lui): zero-extend.
  - All other opcodes: sign-extend.
- **Branch decode (combinational on `id_instr`)**
  - beq (000100): taken if rs == rt.
  - bne (000101): taken if rs != rt.
  - blez (000110): taken if rs signed <= 0.
  - bgtz (000111): taken if rs signed > 0.
  - REGIMM (000001) with rt = 00000 (bltz): taken if rs < 0.
  - REGIMM (000001) with rt = 00001 (bgez): taken if rs >= 0.
  - Taken branch: `npc` = `id_pc4` + (sext(imm) << 2), 32-bit wrap-around, `npc_sel` = 1.
- **Jumps**
  - j (000010) and jal (000011): `npc` = {`id_pc4[31:28]`, `instr[25:0]`, 2'b00}, `npc_sel` = 1.
  - jr (opcode 0, funct 001000): `npc` = `rs_data`, `npc_sel` = 1.
- **Otherwise** `npc_sel` = 0 and `npc` = `id_pc4` + (sext(imm) << 2), a don't-care value that is still deterministic.
- **Delay slot:** the instruction in IF while a transfer sits in ID always executes. `npc` therefore targets the instruction after the delay slot. No flush exists.

## Timing
- One-cycle latency from `if_instr` (sampled at posedge with `id_en` = 1) to `id_instr`.
- `npc` and `npc_sel` are combinational from the registered `id_instr` and the forwarded operands. Fetch consumes them at the next posedge.
- During a stall (`id_en` = 0), `npc_sel` may remain asserted. Fetch holds its PC because its `cont` = 0. The transfer takes effect on the first posedge with `id_en` = 1, once the forwarded operands are valid.
- When reset and `id_en` are both active in the same cycle, reset wins.
- The register file has no read latency. Outputs change within the same cycle as a GRF write or forwarding change.
- Reset values: `id_instr` = 0, `id_pc4` = `RESET_PC`, `rs_data` = `rt_data` = 0 (with forwarding select 0), `ext_imm` = 0, `npc_sel` = 0.

## Structure
- Shared package `mips_defs`:
  - opcode constants (SPECIAL, REGIMM, BEQ, BNE, BLEZ, BGTZ, J, JAL, LUI, ANDI, ORI, XORI);
  - funct JR;
  - REGIMM rt codes;
  - forwarding-select encodings;
  - `RESET_PC`.
- Sub-module `grf`: register file with reset, $0 handling and write bypass.
- Decode, extension and NPC logic stay inline in `id_stage`.

## Test plan
- Reset, then release with `id_en` = 1 and `if_instr` = 0: `id_instr` = 0, `id_pc4` = 32'h00003000, `npc_sel` = 0.
- Write $8 = 5 and $9 = 5, then decode beq $8,$9,+3 with `id_pc4` = 32'h00003008: `npc_sel` = 1, `npc` = 32'h00003014. Change $9 to 6: `npc_sel` = 0.
- `wb_we` = 1, `wb_waddr` = 8, `wb_wdata` = 32'hDEADBEEF while ID reads rs = $8: `rs_data` = 32'hDEADBEEF in the same cycle. Writing $0 leaves reads of $0 at 0.
- bgtz on $10 = 0 with `fwd_rs_sel` = 1 and `fwd_em_data` = 1: `npc_sel` = 1 (forwarded value used).
- jal with index 26'h0000C10 and `id_pc4` = 32'h00003004: `npc` = 32'h00003040. jr $31 with $31 = 32'h0000300C: `npc` = 32'h0000300C.
- Hold `id_en` = 0 for 2 cycles with a changing `if_instr`: `id_instr` and `id_pc4` are held. lui 16'h1234 gives `ext_imm` = 32'h12340000; ori 16'h8000 gives `ext_imm` = 32'h00008000.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package : mips_defs
//  Shared MIPS decode constants: opcodes, funct codes, REGIMM rt codes,
//  operand forwarding-select encodings and the reset PC.
//  Rev 1.0 - initial release
// ============================================================================
package mips_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // REGIMM rt field selects the condition
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    // Operand source selects; both 0 and 3 read the register file
    typedef enum logic [1:0] {
        FWD_GRF  = 2'd0,
        FWD_EM   = 2'd1,
        FWD_MW   = 2'd2,
        FWD_GRF3 = 2'd3
    } fwd_sel_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage : mips_defs
`default_nettype wire

// File: rtl/id_stage_grf.sv
`default_nettype none
// ============================================================================
//  Module : grf
//  32 x 32 general register file, two combinational read ports, one write
//  port. $0 is hard-wired to zero; a write in flight is bypassed to reads
//  of the same address in the same cycle.
//  Rev 1.0 - initial release
// ============================================================================
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];
    logic        wr_active;

    assign wr_active = we_i && (waddr_i != 5'd0);

    // Register array: synchronous clear, writes to $0 dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wr_active) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1 with same-cycle write bypass
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'h0;
        end else if (wr_active && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    // Read port 2 with same-cycle write bypass
    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'h0;
        end else if (wr_active && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule : grf
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module : id_stage
//  MIPS instruction-decode stage: IF/ID register, register file, operand
//  forwarding muxes, immediate extension and control-transfer resolution
//  (branches, j/jal, jr) with one architectural delay slot.
//  Rev 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        id_en,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [1:0]  fwd_rs_sel,
    input  logic [1:0]  fwd_rt_sel,
    input  logic [31:0] fwd_em_data,
    input  logic [31:0] fwd_mw_data,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] ext_imm,
    output logic [31:0] npc,
    output logic        npc_sel
);

    import mips_defs::OP_SPECIAL, mips_defs::OP_REGIMM, mips_defs::OP_J,
           mips_defs::OP_JAL, mips_defs::OP_BEQ, mips_defs::OP_BNE,
           mips_defs::OP_BLEZ, mips_defs::OP_BGTZ, mips_defs::OP_ANDI,
           mips_defs::OP_ORI, mips_defs::OP_XORI, mips_defs::OP_LUI,
           mips_defs::FUNCT_JR, mips_defs::RT_BLTZ, mips_defs::RT_BGEZ,
           mips_defs::FWD_EM, mips_defs::FWD_MW;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;

    logic [5:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] grf_rs;
    logic [31:0] grf_rt;
    logic [31:0] br_target;

    // IF/ID next state: load on id_en, otherwise hold
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (id_en) begin
            instr_d = if_instr;
            pc4_d   = if_pc4;
        end
    end

    // IF/ID register; reset injects a nop at RESET_PC and wins over id_en
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'h0;
            pc4_q   <= RESET_PC;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign id_instr = instr_q;
    assign id_pc4   = pc4_q;

    assign opcode  = instr_q[31:26];
    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];
    assign funct   = instr_q[5:0];
    assign imm     = instr_q[15:0];
    assign jidx    = instr_q[25:0];

    grf u_grf (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_we),
        .waddr_i  (wb_waddr),
        .wdata_i  (wb_wdata),
        .raddr1_i (rs_addr),
        .raddr2_i (rt_addr),
        .rdata1_o (grf_rs),
        .rdata2_o (grf_rt)
    );

    // Operand forwarding muxes; codes 0 and 3 both take the register file
    always_comb begin
        rs_data = grf_rs;
        rt_data = grf_rt;
        case (fwd_rs_sel)
            FWD_EM:  rs_data = fwd_em_data;
            FWD_MW:  rs_data = fwd_mw_data;
            default: rs_data = grf_rs;
        endcase
        case (fwd_rt_sel)
            FWD_EM:  rt_data = fwd_em_data;
            FWD_MW:  rt_data = fwd_mw_data;
            default: rt_data = grf_rt;
        endcase
    end

    // Immediate extension: lui shifts up, logical immediates zero-extend
    always_comb begin
        ext_imm = {{16{imm[15]}}, imm};
        if (opcode == OP_LUI) begin
            ext_imm = {imm, 16'h0};
        end else if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
            ext_imm = {16'h0, imm};
        end
    end

    assign br_target = pc4_q + {{14{imm[15]}}, imm, 2'b00};

    // Control-transfer resolution; npc defaults to the branch target so it
    // stays deterministic when no transfer is taken
    always_comb begin
        npc     = br_target;
        npc_sel = 1'b0;
        case (opcode)
            OP_BEQ:  npc_sel = (rs_data == rt_data);
            OP_BNE:  npc_sel = (rs_data != rt_data);
            OP_BLEZ: npc_sel = ($signed(rs_data) <= 32'sd0);
            OP_BGTZ: npc_sel = ($signed(rs_data) >  32'sd0);
            OP_REGIMM: begin
                if (rt_addr == RT_BLTZ) begin
                    npc_sel = rs_data[31];
                end else if (rt_addr == RT_BGEZ) begin
                    npc_sel = ~rs_data[31];
                end
            end
            OP_J, OP_JAL: begin
                npc     = {pc4_q[31:28], jidx, 2'b00};
                npc_sel = 1'b1;
            end
            OP_SPECIAL: begin
                if (funct == FUNCT_JR) begin
                    npc     = rs_data;
                    npc_sel = 1'b1;
                end
            end
            default: npc_sel = 1'b0;
        endcase
    end

endmodule : id_stage
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module : tb_id_stage
//  Self-checking bench for id_stage: directed scenarios plus randomized
//  instruction/forwarding traffic checked against a behavioural model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc4 = 32'h0;
    logic        id_en = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_waddr = 5'd0;
    logic [31:0] wb_wdata = 32'h0;
    logic [1:0]  fwd_rs_sel = 2'd0;
    logic [1:0]  fwd_rt_sel = 2'd0;
    logic [31:0] fwd_em_data = 32'h0;
    logic [31:0] fwd_mw_data = 32'h0;
    logic [31:0] id_instr, id_pc4, rs_data, rt_data, ext_imm, npc;
    logic        npc_sel;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;

    id_stage dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc4(if_pc4),
        .id_en(id_en), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .fwd_em_data(fwd_em_data), .fwd_mw_data(fwd_mw_data),
        .id_instr(id_instr), .id_pc4(id_pc4), .rs_data(rs_data),
        .rt_data(rt_data), .ext_imm(ext_imm), .npc(npc), .npc_sel(npc_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register read as the architecture defines it, including the write bypass
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we && wb_waddr == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_operand(input logic [1:0] sel, input logic [4:0] a);
        if (sel == 2'd1) return fwd_em_data;
        if (sel == 2'd2) return fwd_mw_data;
        return m_read(a);
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ins);
        int op;
        logic [15:0] im;
        op = int'(ins[31:26]);
        im = ins[15:0];
        if (op == 15) return {im, 16'h0};
        if (op >= 12 && op <= 14) return {16'h0, im};
        return {{16{im[15]}}, im};
    endfunction

    // Expected transfer decision and target from the instruction semantics
    task automatic m_transfer(output logic sel, output logic [31:0] tgt);
        int a, b, op, rtf, off;
        op  = int'(m_instr[31:26]);
        rtf = int'(m_instr[20:16]);
        a   = m_operand(fwd_rs_sel, m_instr[25:21]);
        b   = m_operand(fwd_rt_sel, m_instr[20:16]);
        off = int'($signed(m_instr[15:0]));
        tgt = m_pc4 + 32'(off * 4);
        sel = 1'b0;
        case (op)
            1: sel = (rtf == 0) ? (a < 0) : ((rtf == 1) ? (a >= 0) : 1'b0);
            2, 3: begin sel = 1'b1; tgt = {m_pc4[31:28], m_instr[25:0], 2'b00}; end
            4: sel = (a == b);
            5: sel = (a != b);
            6: sel = (a <= 0);
            7: sel = (a > 0);
            0: if (m_instr[5:0] == 6'd8) begin sel = 1'b1; tgt = a; end
            default: sel = 1'b0;
        endcase
    endtask

    // Advance one clock, applying the same cycle's effects to the model
    task automatic clk_step;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0000_3000;
        end else begin
            if (wb_we && wb_waddr != 5'd0) m_regs[wb_waddr] = wb_wdata;
            if (id_en) begin
                m_instr = if_instr;
                m_pc4   = if_pc4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
        clk_step;
        wb_we = 1'b0;
        #1;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
        if_instr = ins; if_pc4 = pc4; id_en = 1'b1;
        clk_step;
        id_en = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; id_en = 1'b1; if_instr = 32'hFFFF_FFFF; if_pc4 = 32'h1234_5678;
        clk_step; clk_step;
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected %h", id_instr, 32'h0); end
        checks++; if (id_pc4 !== 32'h0000_3000) begin failures++; $display("FAIL reset_pc4: got %h expected %h", id_pc4, 32'h0000_3000); end
        checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin failures++; $display("FAIL reset_operands: got %h/%h expected 0/0", rs_data, rt_data); end
        checks++; if (ext_imm !== 32'h0) begin failures++; $display("FAIL reset_ext: got %h expected 0", ext_imm); end
        checks++; if (npc_sel !== 1'b0) begin failures++; $display("FAIL reset_npc_sel: got %b expected 0", npc_sel); end
        reset = 1'b0; if_instr = 32'h0; if_pc4 = 32'h0000_3000;
        clk_step;
        id_en = 1'b0;
        #1;
        checks++; if (id_instr !== 32'h0 || id_pc4 !== 32'h0000_3000) begin failures++; $display("FAIL release: got %h/%h expected 0/00003000", id_instr, id_pc4); end
        checks++; if (npc_sel !== 1'b0) begin failures++; $display("FAIL release_npc_sel: got %b expected 0", npc_sel); end
    endtask

    task automatic test_beq;
        wr(5'd8, 32'd5);
        wr(5'd9, 32'd5);
        load(32'h1109_0003, 32'h0000_3008);
        checks++; if (npc_sel !== 1'b1) begin failures++; $display("FAIL beq_taken: got %b expected 1", npc_sel); end
        checks++; if (npc !== 32'h0000_3014) begin failures++; $display("FAIL beq_target: got %h expected %h", npc, 32'h0000_3014); end
        wr(5'd9, 32'd6);
        checks++; if (npc_sel !== 1'b0) begin failures++; $display("FAIL beq_not_taken: got %b expected 0", npc_sel); end
    endtask

    task automatic test_bypass;
        wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_same_cycle: got %h expected %h", rs_data, 32'hDEAD_BEEF); end
        clk_step;
        wb_we = 1'b0;
        #1;
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_stored: got %h expected %h", rs_data, 32'hDEAD_BEEF); end
        load(32'h0000_4020, 32'h0000_300C);
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (rs_data !== 32'h0) begin failures++; $display("FAIL zero_bypass: got %h expected 0", rs_data); end
        clk_step;
        wb_we = 1'b0;
        #1;
        checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin failures++; $display("FAIL zero_write: got %h/%h expected 0/0", rs_data, rt_data); end
    endtask

    task automatic test_fwd_bgtz;
        wr(5'd10, 32'd0);
        load(32'h1D40_0004, 32'h0000_3010);
        fwd_rs_sel = 2'd0;
        #1;
        checks++; if (npc_sel !== 1'b0) begin failures++; $display("FAIL bgtz_grf_zero: got %b expected 0", npc_sel); end
        fwd_rs_sel = 2'd1; fwd_em_data = 32'd1;
        #1;
        checks++; if (npc_sel !== 1'b1 || npc !== 32'h0000_3020) begin failures++; $display("FAIL bgtz_fwd_em: got %b/%h expected 1/00003020", npc_sel, npc); end
        fwd_rs_sel = 2'd2; fwd_mw_data = 32'h8000_0000;
        #1;
        checks++; if (npc_sel !== 1'b0 || rs_data !== 32'h8000_0000) begin failures++; $display("FAIL bgtz_fwd_mw_neg: got %b/%h expected 0/80000000", npc_sel, rs_data); end
        fwd_rs_sel = 2'd0;
        #1;
    endtask

    task automatic test_jumps;
        load(32'h0C00_0C10, 32'h0000_3004);
        checks++; if (npc_sel !== 1'b1 || npc !== 32'h0000_3040) begin failures++; $display("FAIL jal: got %b/%h expected 1/00003040", npc_sel, npc); end
        wr(5'd31, 32'h0000_300C);
        load(32'h03E0_0008, 32'h0000_3044);
        checks++; if (npc_sel !== 1'b1 || npc !== 32'h0000_300C) begin failures++; $display("FAIL jr: got %b/%h expected 1/0000300c", npc_sel, npc); end
    endtask

    task automatic test_stall_ext;
        load(32'h3C00_1234, 32'h0000_3050);
        checks++; if (ext_imm !== 32'h1234_0000) begin failures++; $display("FAIL lui_ext: got %h expected %h", ext_imm, 32'h1234_0000); end
        id_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_instr = $urandom; if_pc4 = $urandom;
            clk_step;
            checks++; if (id_instr !== 32'h3C00_1234 || id_pc4 !== 32'h0000_3050) begin failures++; $display("FAIL stall_hold: got %h/%h expected 3c001234/00003050", id_instr, id_pc4); end
        end
        load(32'h3400_8000, 32'h0000_3058);
        checks++; if (id_instr !== 32'h3400_8000) begin failures++; $display("FAIL load_latency: got %h expected %h", id_instr, 32'h3400_8000); end
        checks++; if (ext_imm !== 32'h0000_8000) begin failures++; $display("FAIL ori_ext: got %h expected %h", ext_imm, 32'h0000_8000); end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [5:0]  ops [14];
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        e_sel;
        logic [31:0] e_npc;
        ops = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd12, 6'd13, 6'd14, 6'd15};
        for (int it = 0; it < 400; it++) begin
            op = ops[$urandom_range(0, 13)];
            rs = 5'($urandom_range(0, 7));
            rt = (op == 6'd1) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 7));
            if (op == 6'd0)
                if_instr = {op, rs, rt, 10'($urandom), ($urandom_range(0, 1) == 0) ? 6'd8 : 6'($urandom)};
            else
                if_instr = {op, rs, rt, 16'($urandom)};
            if_pc4      = $urandom & 32'hFFFF_FFFC;
            id_en       = ($urandom_range(0, 3) != 0);
            wb_we       = ($urandom_range(0, 1) == 1);
            wb_waddr    = 5'($urandom_range(0, 7));
            wb_wdata    = rand_val();
            fwd_rs_sel  = 2'($urandom);
            fwd_rt_sel  = 2'($urandom);
            fwd_em_data = rand_val();
            fwd_mw_data = rand_val();
            #1;
            m_transfer(e_sel, e_npc);
            checks++; if (id_instr !== m_instr || id_pc4 !== m_pc4) begin failures++; $display("FAIL rnd_ifid it=%0d: got %h/%h expected %h/%h", it, id_instr, id_pc4, m_instr, m_pc4); end
            checks++; if (rs_data !== m_operand(fwd_rs_sel, m_instr[25:21])) begin failures++; $display("FAIL rnd_rs it=%0d: got %h expected %h", it, rs_data, m_operand(fwd_rs_sel, m_instr[25:21])); end
            checks++; if (rt_data !== m_operand(fwd_rt_sel, m_instr[20:16])) begin failures++; $display("FAIL rnd_rt it=%0d: got %h expected %h", it, rt_data, m_operand(fwd_rt_sel, m_instr[20:16])); end
            checks++; if (ext_imm !== m_ext(m_instr)) begin failures++; $display("FAIL rnd_ext it=%0d: got %h expected %h", it, ext_imm, m_ext(m_instr)); end
            checks++; if (npc_sel !== e_sel || npc !== e_npc) begin failures++; $display("FAIL rnd_npc it=%0d instr=%h: got %b/%h expected %b/%h", it, m_instr, npc_sel, npc, e_sel, e_npc); end
            clk_step;
        end
        wb_we = 1'b0; id_en = 1'b0; fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0;
    endtask

    initial begin
        test_reset;
        test_beq;
        test_bypass;
        test_fwd_bgtz;
        test_jumps;
        test_stall_ext;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_stage
`default_nettype wire
